// File: rtl/values_ram_arbiter.sv
// values_ram_arbiter: shares the single-port values RAM between the CPU
// control unit (port 0) and the debug/program loader (port 1). Each access
// runs IDLE -> ISSUE -> WAIT (RD_LAT cycles) -> DONE, and every output is
// driven from a register.
module values_ram_arbiter #(
  parameter int ADDR_W    = 8,
  parameter int DATA_W    = 8,
  parameter int RD_LAT    = 1,   // 1..4
  parameter int PRIO_MODE = 0    // 0 = round-robin, 1 = port 0 always wins
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              done0,
  output logic [DATA_W-1:0] rdata0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              done1,
  output logic [DATA_W-1:0] rdata1,
  output logic [1:0]        gnt,
  output logic              busy,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  // The counter is loaded with RD_LAT-1, so two bits cover the 1..4 range.
  localparam logic [1:0] CNT_INIT = 2'(RD_LAT - 1);

  state_t              state_q;
  logic [1:0]          cnt_q;
  logic                owner_q;        // 0 = port 0, 1 = port 1
  logic                last_served_q;
  logic                done0_q;
  logic                done1_q;
  logic [DATA_W-1:0]   rdata0_q;
  logic [DATA_W-1:0]   rdata1_q;
  logic [1:0]          gnt_q;
  logic                busy_q;
  logic                ram_en_q;
  logic                ram_we_q;
  logic [ADDR_W-1:0]   ram_addr_q;
  logic [DATA_W-1:0]   ram_wdata_q;
  logic                winner_d;

  // Pick the port to serve if a transaction starts this cycle.
  always_comb begin
    winner_d = 1'b0;
    if (PRIO_MODE != 0) begin
      winner_d = ~req0;
    end else if (req0 && req1) begin
      winner_d = ~last_served_q;
    end else begin
      winner_d = ~req0;
    end
  end

  // Arbitration FSM; all outputs are registered here.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      cnt_q         <= 2'd0;
      owner_q       <= 1'b0;
      last_served_q <= 1'b1;
      done0_q       <= 1'b0;
      done1_q       <= 1'b0;
      rdata0_q      <= '0;
      rdata1_q      <= '0;
      gnt_q         <= 2'b00;
      busy_q        <= 1'b0;
      ram_en_q      <= 1'b0;
      ram_we_q      <= 1'b0;
      ram_addr_q    <= '0;
      ram_wdata_q   <= '0;
    end else begin
      done0_q <= 1'b0;
      done1_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (req0 || req1) begin
            // Latch the winner's command straight into the RAM drivers so
            // later changes on the port cannot disturb this access.
            state_q       <= ISSUE;
            owner_q       <= winner_d;
            last_served_q <= winner_d;
            gnt_q         <= winner_d ? 2'b10 : 2'b01;
            busy_q        <= 1'b1;
            ram_en_q      <= 1'b1;
            ram_we_q      <= winner_d ? we1 : we0;
            ram_addr_q    <= winner_d ? addr1 : addr0;
            ram_wdata_q   <= winner_d ? wdata1 : wdata0;
          end
        end
        ISSUE: begin
          state_q  <= WAIT;
          ram_en_q <= 1'b0;
          ram_we_q <= 1'b0;
          cnt_q    <= CNT_INIT;
        end
        WAIT: begin
          if (cnt_q == 2'd0) begin
            state_q <= DONE;
            if (owner_q) begin
              rdata1_q <= ram_rdata;
              done1_q  <= 1'b1;
            end else begin
              rdata0_q <= ram_rdata;
              done0_q  <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q - 2'd1;
          end
        end
        DONE: begin
          // The served port's req is ignored here; both are re-evaluated in IDLE.
          state_q <= IDLE;
          gnt_q   <= 2'b00;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign done0     = done0_q;
  assign done1     = done1_q;
  assign rdata0    = rdata0_q;
  assign rdata1    = rdata1_q;
  assign gnt       = gnt_q;
  assign busy      = busy_q;
  assign ram_en    = ram_en_q;
  assign ram_we    = ram_we_q;
  assign ram_addr  = ram_addr_q;
  assign ram_wdata = ram_wdata_q;

endmodule

// File: tb/tb_values_ram_arbiter.sv
// Testbench for values_ram_arbiter: three instances (round-robin RD_LAT=1,
// fixed priority RD_LAT=1, round-robin RD_LAT=3), each with a small RAM model.
module tb_values_ram_arbiter;

  localparam int N = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst       [N];
  logic       req0      [N];
  logic       we0       [N];
  logic [7:0] addr0     [N];
  logic [7:0] wdata0    [N];
  logic       req1      [N];
  logic       we1       [N];
  logic [7:0] addr1     [N];
  logic [7:0] wdata1    [N];
  logic       done0     [N];
  logic       done1     [N];
  logic [7:0] rdata0    [N];
  logic [7:0] rdata1    [N];
  logic [1:0] gnt       [N];
  logic       busy      [N];
  logic       ram_en    [N];
  logic       ram_we    [N];
  logic [7:0] ram_addr  [N];
  logic [7:0] ram_wdata [N];
  logic [7:0] ram_rdata [N];

  int checks   = 0;
  int failures = 0;

  for (genvar gi = 0; gi < N; gi++) begin : g_inst
    localparam int LAT  = (gi == 2) ? 3 : 1;
    localparam int PRIO = (gi == 1) ? 1 : 0;

    logic [7:0] mem  [256];
    logic [7:0] pipe [LAT];

    values_ram_arbiter #(
      .ADDR_W(8), .DATA_W(8), .RD_LAT(LAT), .PRIO_MODE(PRIO)
    ) u_dut (
      .clk(clk), .reset(rst[gi]),
      .req0(req0[gi]), .we0(we0[gi]), .addr0(addr0[gi]), .wdata0(wdata0[gi]),
      .done0(done0[gi]), .rdata0(rdata0[gi]),
      .req1(req1[gi]), .we1(we1[gi]), .addr1(addr1[gi]), .wdata1(wdata1[gi]),
      .done1(done1[gi]), .rdata1(rdata1[gi]),
      .gnt(gnt[gi]), .busy(busy[gi]),
      .ram_en(ram_en[gi]), .ram_we(ram_we[gi]),
      .ram_addr(ram_addr[gi]), .ram_wdata(ram_wdata[gi]),
      .ram_rdata(ram_rdata[gi])
    );

    // RAM model: read-first, data valid LAT cycles after the enable cycle.
    always @(posedge clk) begin
      if (rst[gi]) begin
        for (int i = 0; i < 256; i++) mem[i] <= 8'(i);
        mem[8'h10] <= 8'hA5;
        mem[8'h05] <= 8'h11;
        for (int k = 0; k < LAT; k++) pipe[k] <= 8'h00;
      end else begin
        if (ram_en[gi]) begin
          if (ram_we[gi]) mem[ram_addr[gi]] <= ram_wdata[gi];
          pipe[0] <= mem[ram_addr[gi]];
        end
        for (int k = 1; k < LAT; k++) pipe[k] <= pipe[k-1];
      end
    end
    assign ram_rdata[gi] = pipe[LAT-1];
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Follows one transaction that the current inputs will start at the next edge.
  // Called at a negedge in IDLE; returns at the negedge of the following IDLE.
  task automatic observe_txn(input int idx, input int port, input logic we,
                             input logic [7:0] addr, input logic [7:0] wd,
                             input logic [7:0] exp_rd, input bit drop);
    int lat;
    lat = (idx == 2) ? 3 : 1;
    @(negedge clk);  // ISSUE
    check_eq("issue_gnt",   32'(gnt[idx]),    (port == 1) ? 32'd2 : 32'd1);
    check_eq("issue_en",    32'(ram_en[idx]), 32'd1);
    check_eq("issue_we",    32'(ram_we[idx]), 32'(we));
    check_eq("issue_addr",  32'(ram_addr[idx]), 32'(addr));
    check_eq("issue_busy",  32'(busy[idx]),   32'd1);
    if (we) check_eq("issue_wdata", 32'(ram_wdata[idx]), 32'(wd));
    if (drop) begin
      // Drop the requests and scramble the ports; the access must finish intact.
      req0[idx]  = 1'b0;
      req1[idx]  = 1'b0;
      addr0[idx] = addr0[idx] ^ 8'hFF;
      addr1[idx] = addr1[idx] ^ 8'hFF;
      we0[idx]   = ~we0[idx];
      we1[idx]   = ~we1[idx];
    end
    for (int c = 2; c <= lat + 1; c++) begin
      @(negedge clk);  // WAIT
      check_eq("wait_en",   32'(ram_en[idx]), 32'd0);
      check_eq("wait_done", 32'({done1[idx], done0[idx]}), 32'd0);
    end
    @(negedge clk);  // DONE
    check_eq("done_pulse", 32'({done1[idx], done0[idx]}), (port == 1) ? 32'd2 : 32'd1);
    check_eq("done_gnt",   32'(gnt[idx]), (port == 1) ? 32'd2 : 32'd1);
    if (!we) check_eq("done_rdata", (port == 1) ? 32'(rdata1[idx]) : 32'(rdata0[idx]), 32'(exp_rd));
    @(negedge clk);  // IDLE
    check_eq("idle_busy", 32'(busy[idx]), 32'd0);
    check_eq("idle_gnt",  32'(gnt[idx]),  32'd0);
    check_eq("idle_done", 32'({done1[idx], done0[idx]}), 32'd0);
    $display("txn inst=%0d port=%0d we=%0d addr=0x%02h rdata0=0x%02h rdata1=0x%02h",
             idx, port, we, addr, rdata0[idx], rdata1[idx]);
  endtask

  task automatic do_txn(input int idx, input int port, input logic we,
                        input logic [7:0] addr, input logic [7:0] wd, input logic [7:0] exp_rd);
    if (port == 0) begin
      req0[idx] = 1'b1; we0[idx] = we; addr0[idx] = addr; wdata0[idx] = wd;
    end else begin
      req1[idx] = 1'b1; we1[idx] = we; addr1[idx] = addr; wdata1[idx] = wd;
    end
    observe_txn(idx, port, we, addr, wd, exp_rd, 1'b1);
  endtask

  task automatic apply_reset(input int idx);
    rst[idx] = 1'b1;
    @(negedge clk);
    rst[idx] = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      rst[i] = 1'b1;
      req0[i] = 1'b0; we0[i] = 1'b0; addr0[i] = 8'h00; wdata0[i] = 8'h00;
      req1[i] = 1'b0; we1[i] = 1'b0; addr1[i] = 8'h00; wdata1[i] = 8'h00;
    end
    @(negedge clk);
    @(negedge clk);

    // Reset state
    check_eq("rst_gnt",    32'(gnt[0]),       32'd0);
    check_eq("rst_busy",   32'(busy[0]),      32'd0);
    check_eq("rst_en",     32'(ram_en[0]),    32'd0);
    check_eq("rst_we",     32'(ram_we[0]),    32'd0);
    check_eq("rst_addr",   32'(ram_addr[0]),  32'd0);
    check_eq("rst_wdata",  32'(ram_wdata[0]), 32'd0);
    check_eq("rst_done",   32'({done1[0], done0[0]}), 32'd0);
    check_eq("rst_rdata0", 32'(rdata0[0]),    32'd0);
    check_eq("rst_rdata1", 32'(rdata1[0]),    32'd0);
    check_eq("rst_busy_fp", 32'(busy[1]),     32'd0);
    for (int i = 0; i < N; i++) rst[i] = 1'b0;

    // Single read, then write/read on port 1
    do_txn(0, 0, 1'b0, 8'h10, 8'h00, 8'hA5);
    check_eq("rdata0_hold", 32'(rdata0[0]), 32'hA5);
    do_txn(0, 1, 1'b1, 8'h7F, 8'h3C, 8'h00);
    do_txn(0, 1, 1'b0, 8'h7F, 8'h00, 8'h3C);
    check_eq("rdata0_kept", 32'(rdata0[0]), 32'hA5);

    // Round-robin with both requests held from reset
    apply_reset(0);
    req0[0] = 1'b1; we0[0] = 1'b0; addr0[0] = 8'h10;
    req1[0] = 1'b1; we1[0] = 1'b0; addr1[0] = 8'h20;
    observe_txn(0, 0, 1'b0, 8'h10, 8'h00, 8'hA5, 1'b0);
    observe_txn(0, 1, 1'b0, 8'h20, 8'h00, 8'h20, 1'b0);
    observe_txn(0, 0, 1'b0, 8'h10, 8'h00, 8'hA5, 1'b0);
    observe_txn(0, 1, 1'b0, 8'h20, 8'h00, 8'h20, 1'b1);

    // Fixed priority: port 0 keeps winning until it lets go
    req0[1] = 1'b1; we0[1] = 1'b0; addr0[1] = 8'h10;
    req1[1] = 1'b1; we1[1] = 1'b0; addr1[1] = 8'h30;
    observe_txn(1, 0, 1'b0, 8'h10, 8'h00, 8'hA5, 1'b0);
    observe_txn(1, 0, 1'b0, 8'h10, 8'h00, 8'hA5, 1'b0);
    observe_txn(1, 0, 1'b0, 8'h10, 8'h00, 8'hA5, 1'b0);
    req0[1] = 1'b0;
    observe_txn(1, 1, 1'b0, 8'h30, 8'h00, 8'h30, 1'b1);

    // RD_LAT=3 read: done in cycle 5
    do_txn(2, 0, 1'b0, 8'h05, 8'h00, 8'h11);

    // Reset during WAIT discards the transaction
    req0[2] = 1'b1; we0[2] = 1'b0; addr0[2] = 8'h10;
    @(negedge clk);  // ISSUE
    check_eq("rw_issue_gnt", 32'(gnt[2]), 32'd1);
    req0[2] = 1'b0;
    @(negedge clk);  // WAIT
    check_eq("rw_wait_busy", 32'(busy[2]), 32'd1);
    rst[2] = 1'b1;
    @(negedge clk);
    check_eq("rw_gnt",  32'(gnt[2]),    32'd0);
    check_eq("rw_busy", 32'(busy[2]),   32'd0);
    check_eq("rw_en",   32'(ram_en[2]), 32'd0);
    check_eq("rw_done", 32'(done0[2]),  32'd0);
    rst[2] = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check_eq("rw_no_done", 32'({done1[2], done0[2]}), 32'd0);
      check_eq("rw_idle",    32'(busy[2]), 32'd0);
    end
    // last_served is back to 1, so port 0 wins a simultaneous request
    req0[2] = 1'b1; we0[2] = 1'b0; addr0[2] = 8'h10;
    req1[2] = 1'b1; we1[2] = 1'b0; addr1[2] = 8'h05;
    observe_txn(2, 0, 1'b0, 8'h10, 8'h00, 8'hA5, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/values_ram_arbiter.md
Name: values_ram_arbiter

Overview:
- Shares the single-port values RAM between two requesters: port 0 is the CPU control unit (load/store/PUSH/POP/jump-target reads), port 1 is the debug/program loader.
- Serialises accesses with a req/done handshake and drives the RAM address, data, write-enable and enable lines.
- Sits between the control unit's values-RAM bus and the values RAM macro. Replaces the control unit driving the RAM clock/enable directly.

Parameters:
- ADDR_W, 8, values RAM address width.
- DATA_W, 8, values RAM data width.
- RD_LAT, 1, RAM read latency in cycles from enable to valid rdata. Legal range 1..4.
- PRIO_MODE, 0, 0 = round-robin; 1 = fixed priority with port 0 always winning.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high.
- req0  in  1  port 0 request; must be held until done0.
- we0  in  1  port 0 write (1) / read (0); stable while req0 is high.
- addr0  in  ADDR_W  port 0 address.
- wdata0  in  DATA_W  port 0 write data.
- done0  out  1  one-cycle pulse: port 0 transaction complete.
- rdata0  out  DATA_W  port 0 read data; valid while done0=1, held until next port 0 done.
- req1, we1, addr1, wdata1, done1, rdata1: same definitions for port 1.
- gnt  out  2  one-hot owner of the current transaction; 00 when idle.
- busy  out  1  1 in any state other than IDLE.
- ram_en  out  1  RAM access strobe.
- ram_we  out  1  RAM write enable.
- ram_addr  out  ADDR_W  RAM address.
- ram_wdata  out  DATA_W  RAM write data.
- ram_rdata  in  DATA_W  RAM read data.

Behaviour:
- All outputs are registered.
- Reset values: done0/1=0, rdata0/1=0, gnt=00, busy=0, ram_en=0, ram_we=0, ram_addr=0, ram_wdata=0, state=IDLE, wait counter=0, last_served=1 (port 0 preferred first).
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE: if any req is high, select a winner; latch its we/addr/wdata; go to ISSUE. Otherwise stay in IDLE.
- Winner selection:
  - PRIO_MODE=0: a lone requester wins. If both request, the port not equal to last_served wins. last_served updates on entry to ISSUE.
  - PRIO_MODE=1: port 0 wins whenever req0=1.
- ISSUE (exactly 1 cycle): ram_en=1; ram_we=latched we; ram_addr/ram_wdata from the latched values; gnt=winner. Next state is WAIT with counter=RD_LAT-1.
- WAIT: ram_en=0, ram_we=0, gnt held. Decrement the counter; when it is 0, capture ram_rdata into the winner's rdata register and go to DONE.
- DONE (1 cycle): done pulses on the winner's port; gnt held; next state is always IDLE.
  - The served port's req seen during DONE is not a new request.
  - Both ports are re-evaluated in IDLE.
- Writes use the same timing as reads. rdata of the writer is updated with whatever the RAM returns; callers ignore it.
- Timeline, with req sampled high in cycle 0:
  - cycle 1: ISSUE.
  - cycles 2..1+RD_LAT: WAIT.
  - cycle 2+RD_LAT: DONE.
  - cycle 3+RD_LAT: IDLE.
  - Latency req→done = 2+RD_LAT cycles (3 for RD_LAT=1). Peak throughput is one access per 3+RD_LAT cycles.
- Requests seen in ISSUE, WAIT or DONE are not lost: a request held high is serviced from the next IDLE.
- Address, data and write-enable changes on a port after it has been latched have no effect on the current transaction.
- Dropping req mid-transaction does not abort it; done still pulses.
- Reset in any state: outputs return to reset values on the next edge, and the in-flight transaction is discarded with no done. A write already issued in ISSUE is not undone.
- gnt is never 11; done0 and done1 are never high together.

Test Plan:
- Single read, RD_LAT=1, RAM[0x10]=0xA5: req0, we0=0, addr0=0x10 in cycle 0 → ISSUE in cycle 1 with ram_en=1, ram_we=0, ram_addr=0x10, gnt=01; done0=1 and rdata0=0xA5 in cycle 3; busy low in cycle 4.
- Write then read, port 1: write 0x3C to 0x7F (ram_we=1, ram_wdata=0x3C in ISSUE), done1 after 3 cycles; then read 0x7F → rdata1=0x3C.
- Round-robin, PRIO_MODE=0: req0 and req1 held high continuously → grant sequence 01,10,01,10 from reset, one done every 4 cycles.
- Fixed priority, PRIO_MODE=1: both requests held high → port 0 served every transaction, done1 never pulses; drop req0 → port 1 served next IDLE.
- RD_LAT=3: read 0x05 (RAM value 0x11) → done0 in cycle 5, rdata0=0x11.
- Reset asserted in WAIT of a port-0 read → no done0; next cycle gnt=00, busy=0, ram_en=0; a subsequent req1 with req0 also high is granted to port 0 first (last_served reset to 1).
